panel_nav_ctrl: RTL
===================

PANEL_NAV_CTRL -- requirements
Module: panel_nav_ctrl

Interface
REQ-001 Parameter REPEAT_DELAY, default 12500000: held-direction cycles before the first auto-repeat move.
REQ-002 Parameter REPEAT_PERIOD, default 5000000: cycles between later auto-repeat moves.
REQ-003 vga_clk  in  1  sole clock; all logic on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 key_dir  in  4  debounced direction levels: bit2 Up, bit0 Right, bit3 Left, bit1 Down.
REQ-006 key_ok  in  1  debounced confirm level.
REQ-007 enable_panel  in  8  panel enable mask; bit i = panel i; grid row = i>>1, column = i[0].
REQ-008 cursor  out  3  highlighted panel index.
REQ-009 cursor_valid  out  1  high when enable_panel != 0.
REQ-010 highlight  out  8  one-hot of cursor, gated by cursor_valid.
REQ-011 sel_valid  out  1  selection request to consumer.
REQ-012 sel_id  out  3  selected panel, stable while sel_valid is high.
REQ-013 sel_ready  in  1  consumer accept.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 Inputs are registered once; a rising edge of the registered level is an event.
REQ-016 Simultaneous direction events use priority Up > Right > Left > Down; the others are dropped.
REQ-017 The FSM has four states: IDLE, SEARCH, SEL_WAIT, RELOCATE.
REQ-018 IDLE, direction event, cursor_valid=1 -> SEARCH; in IDLE with cursor_valid=0, events are ignored.
REQ-019 Left/Right: the candidate is the other column of the same row; SEARCH lasts 1 cycle; move if enabled, else stay; no wrap.
REQ-020 Up/Down: candidates step row by row, same column, wrapping modulo 4 rows, one candidate per cycle, at most 3 cycles.
REQ-021 The first enabled candidate is loaded into cursor on the cycle after it is examined; if no candidate is enabled, the cursor is unchanged; then -> IDLE.
REQ-022 Event-to-cursor latency: 2 cycles after the registered edge for horizontal moves, 2..4 cycles for vertical moves.
REQ-023 IDLE, key_ok event, cursor_valid=1 -> SEL_WAIT; sel_valid=1 and sel_id=cursor on the next cycle.
REQ-024 SEL_WAIT: sel_valid is held until a cycle where sel_ready=1; sel_valid=0 the next cycle; -> IDLE.
REQ-025 sel_ready while sel_valid=0 has no effect.
REQ-026 Direction and key_ok events during SEARCH or SEL_WAIT are discarded, not queued.
REQ-027 In IDLE, if enable_panel[cursor]=0 and the mask is nonzero -> RELOCATE.
REQ-028 RELOCATE loads the lowest-index enabled panel into cursor in 1 cycle, then -> IDLE.
REQ-029 If the mask becomes 0: cursor holds its value, cursor_valid=0, highlight=0.
REQ-030 A mask change during SEARCH uses the current mask per candidate cycle.
REQ-031 A mask change during SEL_WAIT does not alter sel_id.

Reset
REQ-032 While rst=1: state=IDLE, cursor=0, sel_valid=0, sel_id=0, busy=0, input registers=0, repeat counter=0.
REQ-033 An assertion mid-SEARCH or mid-SEL_WAIT aborts the operation; no sel_valid pulse follows reset.
REQ-034 After deassertion, keys already held produce no event until released and pressed again.

Configuration
REQ-035 Macro NAV_AUTOREPEAT_EN, when defined: a direction held alone in IDLE for REPEAT_DELAY cycles generates one synthetic event, then one every REPEAT_PERIOD cycles until release.
REQ-036 Under NAV_AUTOREPEAT_EN, the repeat counter clears on release, on a change of direction, and outside IDLE.
REQ-037 Macro undefined: no repeat counter is built, and only edges produce events.

Verification
REQ-038 Reset, mask=FF, Right pulse -> cursor=1, highlight=02, 2 cycles after the registered edge.
REQ-039 mask=0x41, cursor=0, Up -> cursor=6 after a 3-cycle search (rows 3,2,1 examined; row 3 hit first); mask=0x01, Down -> cursor stays 0, back to IDLE after 3 search cycles.
REQ-040 cursor=3, key_ok, sel_ready low 5 cycles then high -> sel_valid high 6 cycles with sel_id=3; a Down pulse during the wait is ignored.
REQ-041 cursor=5, mask 0xFF->0x18 -> cursor=3 after 1 RELOCATE cycle; mask->0x00 -> cursor_valid=0, highlight=00.
REQ-042 Up+Left asserted in the same cycle from cursor=2 -> cursor=0 (Up wins).
REQ-043 NAV_AUTOREPEAT_EN with REPEAT_DELAY=10 and REPEAT_PERIOD=4, Down held from cursor=0 with mask=FF -> moves to 2 on the edge, 4 after 10 cycles, 6 after 4 more; rst mid-hold -> cursor=0 and no further moves.

Source files
------------

// File: rtl/panel_nav_ctrl.sv
// rtl/panel_nav_ctrl.sv - cursor navigation over a 4x2 panel grid with selection handshake (optional NAV_AUTOREPEAT_EN)
module panel_nav_ctrl #(
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic [3:0] key_dir,
  input  logic       key_ok,
  input  logic [7:0] enable_panel,
  output logic [2:0] cursor,
  output logic       cursor_valid,
  output logic [7:0] highlight,
  output logic       sel_valid,
  output logic [2:0] sel_id,
  input  logic       sel_ready,
  output logic       busy
);

  // key_dir bit positions
  localparam int DIR_RIGHT = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_LEFT  = 3;

  typedef enum logic [1:0] {IDLE, SEARCH, SEL_WAIT, RELOCATE} state_t;
  typedef enum logic [1:0] {MV_RIGHT, MV_LEFT, MV_UP, MV_DOWN} move_t;

  state_t     state, state_nxt;
  move_t      move_q, move_nxt;

  logic [3:0] dir_r, dir_d;
  logic       ok_r, ok_d;
  logic [4:0] key_blk;

  logic [2:0] cursor_nxt;
  logic [2:0] cand_q, cand_nxt;
  logic       cand_ok_q, cand_ok_nxt;
  logic       found_q, found_nxt;
  logic [1:0] step_q, step_nxt;
  logic       sel_valid_nxt;
  logic [2:0] sel_id_nxt;

  logic [3:0] dir_ev;
  logic       ok_ev;
  logic       rpt_fire;

  logic [1:0] cur_row;
  logic       cur_col;

  assign cur_row = cursor[2:1];
  assign cur_col = cursor[0];

  // Register the keys once, keep the previous registered level for edge detection,
  // and block any key that was already held when reset released until it is let go.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      dir_r   <= 4'b0;
      dir_d   <= 4'b0;
      ok_r    <= 1'b0;
      ok_d    <= 1'b0;
      key_blk <= 5'h1f;
    end else begin
      dir_r   <= key_dir;
      dir_d   <= dir_r;
      ok_r    <= key_ok;
      ok_d    <= ok_r;
      key_blk <= key_blk & {key_ok, key_dir};
    end
  end

  // A synthetic repeat event re-injects the currently held (single) direction.
  assign dir_ev = (dir_r & ~dir_d & ~key_blk[3:0]) | (rpt_fire ? dir_r : 4'b0);
  assign ok_ev  = ok_r & ~ok_d & ~key_blk[4];

`ifdef NAV_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;
  logic             held_one;

  // Only a lone, steady, unblocked direction counts, and only while IDLE.
  assign held_one = (state == IDLE) && $onehot(dir_r) && (dir_r == dir_d) &&
                    ((dir_r & key_blk[3:0]) == 4'b0);
  assign rpt_fire = held_one && (rpt_cnt == (rpt_armed ? PERIOD_LAST : DELAY_LAST));

  // Repeat timer: first fire after the delay, later fires every period; the armed
  // flag survives the move itself so subsequent repeats use the period.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if ((dir_r == 4'b0) || (dir_r != dir_d)) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (!held_one) begin
      rpt_cnt   <= '0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt + 1'b1;
    end
  end
`else
  // No repeat logic; low for any legal (non-negative) timing parameters.
  assign rpt_fire = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

  // State and datapath registers for the navigation FSM.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      move_q    <= MV_RIGHT;
      cursor    <= 3'd0;
      cand_q    <= 3'd0;
      cand_ok_q <= 1'b0;
      found_q   <= 1'b0;
      step_q    <= 2'd0;
      sel_valid <= 1'b0;
      sel_id    <= 3'd0;
    end else begin
      state     <= state_nxt;
      move_q    <= move_nxt;
      cursor    <= cursor_nxt;
      cand_q    <= cand_nxt;
      cand_ok_q <= cand_ok_nxt;
      found_q   <= found_nxt;
      step_q    <= step_nxt;
      sel_valid <= sel_valid_nxt;
      sel_id    <= sel_id_nxt;
    end
  end

  // Next-state logic: event dispatch in IDLE, candidate scan in SEARCH,
  // handshake in SEL_WAIT, lowest-enabled fallback in RELOCATE.
  always_comb begin
    state_nxt     = state;
    move_nxt      = move_q;
    cursor_nxt    = cursor;
    cand_nxt      = cand_q;
    cand_ok_nxt   = cand_ok_q;
    found_nxt     = found_q;
    step_nxt      = step_q;
    sel_valid_nxt = sel_valid;
    sel_id_nxt    = sel_id;

    case (state)
      IDLE: begin
        if (cursor_valid) begin
          if (!enable_panel[cursor]) begin
            state_nxt = RELOCATE;
          end else if (|dir_ev) begin
            state_nxt = SEARCH;
            step_nxt  = 2'd0;
            found_nxt = 1'b0;
            if (dir_ev[DIR_UP]) begin
              move_nxt    = MV_UP;
              cand_nxt    = {cur_row - 2'd1, cur_col};
              cand_ok_nxt = 1'b1;
            end else if (dir_ev[DIR_RIGHT]) begin
              move_nxt    = MV_RIGHT;
              cand_nxt    = {cur_row, 1'b1};
              cand_ok_nxt = ~cur_col;
            end else if (dir_ev[DIR_LEFT]) begin
              move_nxt    = MV_LEFT;
              cand_nxt    = {cur_row, 1'b0};
              cand_ok_nxt = cur_col;
            end else begin
              move_nxt    = MV_DOWN;
              cand_nxt    = {cur_row + 2'd1, cur_col};
              cand_ok_nxt = 1'b1;
            end
          end else if (ok_ev) begin
            state_nxt     = SEL_WAIT;
            sel_valid_nxt = 1'b1;
            sel_id_nxt    = cursor;
          end
        end
      end

      SEARCH: begin
        // The first enabled candidate wins; later candidates are still scanned
        // so a vertical search always spans three rows.
        if (cand_ok_q && !found_q && enable_panel[cand_q]) begin
          cursor_nxt = cand_q;
          found_nxt  = 1'b1;
        end
        if ((move_q == MV_RIGHT) || (move_q == MV_LEFT) || (step_q == 2'd2)) begin
          state_nxt = IDLE;
        end else begin
          step_nxt = step_q + 2'd1;
          if (move_q == MV_UP) cand_nxt = {cand_q[2:1] - 2'd1, cand_q[0]};
          else                 cand_nxt = {cand_q[2:1] + 2'd1, cand_q[0]};
        end
      end

      SEL_WAIT: begin
        if (sel_ready) begin
          sel_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      RELOCATE: begin
        for (int i = 7; i >= 0; i--) begin
          if (enable_panel[i]) cursor_nxt = 3'(i);
        end
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign cursor_valid = |enable_panel;
  assign highlight    = cursor_valid ? (8'b1 << cursor) : 8'b0;
  assign busy         = (state != IDLE);

endmodule
